svc_rv_div_seq: RTL and testbench

Sequencer for the M-extension iterative divider in the RV execute stage. Accepts one DIV/DIVU/REM/REMU request at a time from EX and runs a radix-2 restoring divide over XLEN cycles. Short-circuits divide-by-zero, signed overflow and back-to-back DIV/REM pairs on identical operands. Holds the result until EX consumes it, and abandons the operation on a pipeline flush.

---
 rtl/svc_rv_div_seq_pkg.sv | 22 ++
 rtl/svc_rv_div_step.sv | 30 +++
 rtl/svc_rv_div_seq.sv | 209 ++++++++++++++++++++
 tb/tb_svc_rv_div_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_div_seq_pkg.sv
// Purpose: shared constants and helpers for the RV M-extension divide sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
//   Contents: funct3 encodings for DIV/DIVU/REM/REMU and op-decoding helpers.
package svc_rv_div_seq_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    // funct3[0] clear selects the signed variants (DIV, REM).
    function automatic logic op_is_signed(input logic [2:0] op);
        return !op[0];
    endfunction

    // funct3[1] set selects the remainder (REM, REMU) instead of the quotient.
    function automatic logic op_is_rem(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/svc_rv_div_step.sv
// Purpose: one radix-2 restoring divide iteration (shift in dividend MSB, trial subtract).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   Ports: rem_in/q_in/divisor -> rem_out/q_out. q_in carries the not-yet-consumed
//   dividend bits in its upper part and the quotient bits built so far in its lower part.
module svc_rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] q_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] q_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            borrow;

    always_comb begin
        shifted = {rem_in, q_in[XLEN-1]};
        borrow  = shifted < {1'b0, divisor};
        // When there is no borrow the true difference is below the divisor, so
        // the low XLEN bits of the modular difference are exact.
        diff    = shifted[XLEN-1:0] - divisor;
        rem_out = borrow ? shifted[XLEN-1:0] : diff;
        q_out   = {q_in[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/svc_rv_div_seq.sv
// Purpose: sequencer for the iterative RV divider (DIV/DIVU/REM/REMU), one op at a time.
// Latency: XLEN+1 cycles accept-to-result iterative; 1 cycle for div-by-zero/overflow/reuse.
// Backpressure: result held in DONE until rsp_ready; req_ready low outside IDLE and on flush.
//   Ports: req_valid/req_ready/req_op/req_a/req_b (request from EX), flush (kill op),
//   rsp_valid/rsp_ready/rsp_result (result to EX), busy (registered, drives EX stall).
module svc_rv_div_seq
    import svc_rv_div_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FAST_PATH = 1,
    parameter int REUSE     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    // Latched request; a_lat/b_lat/sgn_lat/kind_lat double as the reuse tag.
    logic [XLEN-1:0] a_lat;
    logic [XLEN-1:0] b_lat;
    logic            sgn_lat;
    logic            kind_lat;
    logic            ent_vld;

    // Iteration datapath: magnitudes and sign-fix flags.
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic            neg_q;
    logic            neg_r;

    // Sign-corrected results of the last completed op (reuse payload).
    logic [XLEN-1:0] q_hold;
    logic [XLEN-1:0] r_hold;

    logic            accept;
    logic            req_sgn;
    logic            req_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            fast_zero;
    logic            fast_ovf;
    logic            reuse_hit;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_q;
    logic [XLEN-1:0] fin_q;
    logic [XLEN-1:0] fin_r;

    assign req_ready = (state == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_sgn   = op_is_signed(req_op);
        req_rem   = op_is_rem(req_op);
        a_neg     = req_sgn && req_a[XLEN-1];
        b_neg     = req_sgn && req_b[XLEN-1];
        abs_a     = a_neg ? (~req_a + 1'b1) : req_a;
        abs_b     = b_neg ? (~req_b + 1'b1) : req_b;
        fast_zero = (FAST_PATH != 0) && (req_b == '0);
        fast_ovf  = (FAST_PATH != 0) && req_sgn && (req_a == INT_MIN) && (req_b == '1);
        // funct3[2] is set for every divide encoding, so a stray non-divide
        // funct3 can never pick up a held result.
        reuse_hit = (REUSE != 0) && ent_vld && req_op[2]
                    && (req_a == a_lat) && (req_b == b_lat)
                    && (req_sgn == sgn_lat) && (req_rem != kind_lat);
    end

    svc_rv_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in  (rem),
        .q_in    (quo),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    // A zero divisor leaves the quotient at all-ones unnegated; the remainder
    // still gets its fix so that |a| comes back out as the original a.
    always_comb begin
        fin_q = (neg_q && (dvs != '0)) ? (~step_q + 1'b1) : step_q;
        fin_r = neg_r ? (~step_rem + 1'b1) : step_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            a_lat      <= '0;
            b_lat      <= '0;
            sgn_lat    <= 1'b0;
            kind_lat   <= 1'b0;
            ent_vld    <= 1'b0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            q_hold     <= '0;
            r_hold     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_lat    <= req_a;
                        b_lat    <= req_b;
                        sgn_lat  <= req_sgn;
                        kind_lat <= req_rem;
                        busy     <= 1'b1;
                        if (fast_zero) begin
                            q_hold     <= '1;
                            r_hold     <= req_a;
                            rsp_result <= req_rem ? req_a : '1;
                            ent_vld    <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else if (fast_ovf) begin
                            q_hold     <= req_a;
                            r_hold     <= '0;
                            rsp_result <= req_rem ? '0 : req_a;
                            ent_vld    <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else if (reuse_hit) begin
                            // Entry stays valid; kind_lat now tracks this op so
                            // the pair can keep alternating.
                            rsp_result <= req_rem ? r_hold : q_hold;
                            rsp_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            ent_vld <= 1'b0;
                            dvs     <= abs_b;
                            quo     <= abs_a;
                            rem     <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            count   <= CW'(XLEN - 1);
                            state   <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        rem <= step_rem;
                        quo <= step_q;
                        if (count == '0) begin
                            q_hold     <= fin_q;
                            r_hold     <= fin_r;
                            rsp_result <= kind_lat ? fin_r : fin_q;
                            ent_vld    <= (REUSE != 0);
                            rsp_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Flush and consume both retire the op; flush just means
                    // EX never saw it.
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svc_rv_div_seq.sv
module tb_svc_rv_div_seq;
    import svc_rv_div_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [1:0]  flush;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result [2];
    logic [1:0]  busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q [$];

    typedef struct {
        int          inst;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    svc_rv_div_seq #(.XLEN(32), .FAST_PATH(1), .REUSE(1)) dut_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_op     (req_op[0]),
        .req_a      (req_a[0]),
        .req_b      (req_b[0]),
        .flush      (flush[0]),
        .rsp_valid  (rsp_valid[0]),
        .rsp_ready  (rsp_ready[0]),
        .rsp_result (rsp_result[0]),
        .busy       (busy[0])
    );

    svc_rv_div_seq #(.XLEN(32), .FAST_PATH(0), .REUSE(1)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_op     (req_op[1]),
        .req_a      (req_a[1]),
        .req_b      (req_b[1]),
        .flush      (flush[1]),
        .rsp_valid  (rsp_valid[1]),
        .rsp_ready  (rsp_ready[1]),
        .rsp_result (rsp_result[1]),
        .busy       (busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference results from native operators, RISC-V corner rules applied.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic vec_t mk(input int inst, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res, input int lat);
        vec_t v;
        v.inst = inst; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
        return v;
    endfunction

    task automatic start_op(input int inst, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, output bit ok);
        int n;
        @(negedge clk);
        req_valid[inst] = 1'b1;
        req_op[inst]    = op;
        req_a[inst]     = a;
        req_b[inst]     = b;
        n = 0;
        while (!req_ready[inst] && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready[inst];
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout inst=%0d actual=req_ready_low required=accept", inst);
        end
        req_valid[inst] = 1'b0;
    endtask

    task automatic wait_rsp(input int inst, output int lat, output bit ok);
        lat = 1;
        while (!rsp_valid[inst] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = rsp_valid[inst];
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout inst=%0d actual=no_rsp_valid required=rsp_valid", inst);
        end
    endtask

    task automatic consume(input int inst);
        rsp_ready[inst] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[inst] = 1'b0;
        chk($sformatf("busy_after_consume%0d", inst), {31'b0, busy[inst]}, 32'h0);
    endtask

    task automatic do_op(input int inst, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input string name);
        bit          ok;
        int          lat;
        logic [31:0] exp;
        sb_q.push_back(exp_res);
        start_op(inst, op, a, b, ok);
        if (!ok) begin
            void'(sb_q.pop_front());
            return;
        end
        wait_rsp(inst, lat, ok);
        exp = sb_q.pop_front();
        if (!ok) return;
        chk({name, "_result"}, rsp_result[inst], exp);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        consume(inst);
    endtask

    initial begin
        bit          ok;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  oq;
        logic [2:0]  orr;

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        flush     = '0;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = FUNCT3_DIV;
            req_a[i]  = '0;
            req_b[i]  = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy[0]}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        chk("rst_rsp_result", rsp_result[0], 32'h0);
        chk("rst_req_ready", {31'b0, req_ready[0]}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors; latency depends on the reuse entry left by the previous row.
        tbl.push_back(mk(0, FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 33));
        tbl.push_back(mk(0, FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 1));
        tbl.push_back(mk(0, FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33));
        tbl.push_back(mk(0, FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(0, FUNCT3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33));
        tbl.push_back(mk(0, FUNCT3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(0, FUNCT3_REMU, 32'd5, 32'd0, 32'd5, 1));
        tbl.push_back(mk(0, FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
        tbl.push_back(mk(0, FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1));
        tbl.push_back(mk(0, FUNCT3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33));
        tbl.push_back(mk(0, FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33));
        tbl.push_back(mk(0, FUNCT3_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33));
        tbl.push_back(mk(0, FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33));
        tbl.push_back(mk(0, FUNCT3_DIV, 32'd100, 32'd7, 32'd14, 33));
        tbl.push_back(mk(0, FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 33));
        tbl.push_back(mk(1, FUNCT3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 33));
        tbl.push_back(mk(1, FUNCT3_REMU, 32'd5, 32'd0, 32'd5, 33));
        tbl.push_back(mk(1, FUNCT3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 33));
        tbl.push_back(mk(1, FUNCT3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1));
        tbl.push_back(mk(1, FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33));
        tbl.push_back(mk(1, FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i].inst, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat,
                  $sformatf("vec%0d", i));
        end

        // Result held while rsp_ready stays low; no new request taken.
        start_op(0, FUNCT3_DIVU, 32'd300, 32'd7, ok);
        if (ok) begin
            wait_rsp(0, lat, ok);
            if (ok) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    req_valid[0] = 1'b1;
                    req_op[0]    = FUNCT3_DIV;
                    req_a[0]     = 32'd1;
                    req_b[0]     = 32'd1;
                    chk($sformatf("hold%0d_valid", k), {31'b0, rsp_valid[0]}, 32'h1);
                    chk($sformatf("hold%0d_result", k), rsp_result[0], 32'd42);
                    chk($sformatf("hold%0d_req_ready", k), {31'b0, req_ready[0]}, 32'h0);
                end
                @(negedge clk);
                req_valid[0] = 1'b0;
                consume(0);
            end
        end

        // Flush in the middle of CALC: no response, entry left invalid.
        start_op(0, FUNCT3_DIV, 32'd1000, 32'd3, ok);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        chk("flush_busy", {31'b0, busy[0]}, 32'h0);
        chk("flush_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        repeat (30) @(posedge clk);
        #1;
        chk("flush_no_late_rsp", {31'b0, rsp_valid[0]}, 32'h0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        flush[0]     = 1'b1;
        req_valid[0] = 1'b1;
        req_op[0]    = FUNCT3_DIVU;
        req_a[0]     = 32'd9;
        req_b[0]     = 32'd0;
        #1;
        chk("idle_flush_req_ready", {31'b0, req_ready[0]}, 32'h0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        chk("idle_flush_not_taken", {31'b0, busy[0]}, 32'h0);

        do_op(0, FUNCT3_REM, 32'd1000, 32'd3, 32'd1, 33, "rem_after_flush");

        // Flush wins over rsp_ready in DONE.
        start_op(0, FUNCT3_DIVU, 32'd5, 32'd0, ok);
        @(negedge clk);
        flush[0]     = 1'b1;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0]     = 1'b0;
        rsp_ready[0] = 1'b0;
        chk("done_flush_valid", {31'b0, rsp_valid[0]}, 32'h0);
        chk("done_flush_busy", {31'b0, busy[0]}, 32'h0);

        // Asynchronous reset mid-CALC.
        start_op(0, FUNCT3_DIVU, 32'd200, 32'd9, ok);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy[0]}, 32'h0);
        chk("arst_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        chk("arst_rsp_result", rsp_result[0], 32'h0);
        chk("arst_req_ready", {31'b0, req_ready[0]}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset drops a valid reuse entry.
        do_op(0, FUNCT3_DIVU, 32'd200, 32'd9, 32'd22, 33, "pre_rst_divu");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, FUNCT3_REMU, 32'd200, 32'd9, 32'd2, 33, "post_rst_remu");

        // Random quotient/remainder pairs against the reference model.
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b >> 20;
            if (b == 32'h0) b = 32'd3;
            if (a == 32'h8000_0000) a = 32'd1;
            if ($urandom_range(0, 1) == 1) begin
                oq = FUNCT3_DIV; orr = FUNCT3_REM;
            end else begin
                oq = FUNCT3_DIVU; orr = FUNCT3_REMU;
            end
            do_op(0, oq, a, b, ref_div(oq, a, b), 33, $sformatf("rnd%0d_q", i));
            do_op(0, orr, a, b, ref_div(orr, a, b), 1, $sformatf("rnd%0d_r", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
